// File: rtl/dist_sqrt_unit_if.sv
// dist_sqrt_unit_if: controller-side handshake and data bundle for the iterative square-root stage
//   RST_Sqrt  ctrl->sqrt  synchronous soft clear
//   EN_Sqrt   ctrl->sqrt  start/hold request, level-sensitive
//   DIN_Sqrt  ctrl->sqrt  unsigned radicand, IN_WIDTH bits
//   RDY_Sqrt  sqrt->ctrl  registered result-valid
//   DOUT_Sqrt sqrt->ctrl  registered unsigned root, IN_WIDTH/2 bits
//   BUSY_Sqrt sqrt->ctrl  high while an iteration is in flight
interface dist_sqrt_unit_if #(parameter int IN_WIDTH = 32) ();
  logic                    RST_Sqrt;
  logic                    EN_Sqrt;
  logic [IN_WIDTH-1:0]     DIN_Sqrt;
  logic                    RDY_Sqrt;
  logic [IN_WIDTH/2-1:0]   DOUT_Sqrt;
  logic                    BUSY_Sqrt;
  modport master (output RST_Sqrt, EN_Sqrt, DIN_Sqrt, input RDY_Sqrt, DOUT_Sqrt, BUSY_Sqrt);
  modport slave  (input RST_Sqrt, EN_Sqrt, DIN_Sqrt, output RDY_Sqrt, DOUT_Sqrt, BUSY_Sqrt);
endinterface

// File: rtl/dist_sqrt_unit.sv
// dist_sqrt_unit: restoring digit-by-digit integer square root, one root bit per cycle
//   clk   rising-edge clock
//   RST_N asynchronous active-low reset
//   sq    dist_sqrt_unit_if.slave (RST_Sqrt, EN_Sqrt, DIN_Sqrt in; RDY_Sqrt, DOUT_Sqrt, BUSY_Sqrt out)
//   SQRT_ROUND_EN (macro) adds a ROUND state giving round-to-nearest with saturation
module dist_sqrt_unit #(
  parameter int IN_WIDTH = 32
) (
  input  logic            clk,
  input  logic            RST_N,
  dist_sqrt_unit_if.slave sq
);
  localparam int OW = IN_WIDTH / 2;
  localparam int RW = OW + 2;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
`ifdef SQRT_ROUND_EN
  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif
  state_t              state, state_n;
  logic [IN_WIDTH-1:0] rad, rad_n;
  logic [RW-1:0]       rem, rem_n;
  logic [OW-1:0]       root, root_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                rdy, rdy_n;
  logic [OW-1:0]       dout, dout_n;
  logic [RW-1:0]       rem_sh, trial;
  logic                ge;
  // The remainder never exceeds twice the partial root, so its top two bits are always zero before the shift
  assign rem_sh = RW'({rem, rad[IN_WIDTH-1 -: 2]});
  assign trial  = {root, 2'b01};
  assign ge     = rem_sh >= trial;
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      rad   <= '0;
      rem   <= '0;
      root  <= '0;
      cnt   <= '0;
      rdy   <= 1'b0;
      dout  <= '0;
    end else begin
      state <= state_n;
      rad   <= rad_n;
      rem   <= rem_n;
      root  <= root_n;
      cnt   <= cnt_n;
      rdy   <= rdy_n;
      dout  <= dout_n;
    end
  end
  always_comb begin
    state_n = state;
    rad_n   = rad;
    rem_n   = rem;
    root_n  = root;
    cnt_n   = cnt;
    rdy_n   = rdy;
    dout_n  = dout;
    if (sq.RST_Sqrt) begin
      state_n = IDLE;
      rdy_n   = 1'b0;
      dout_n  = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: if (sq.EN_Sqrt) begin
          state_n = CALC;
          rad_n   = sq.DIN_Sqrt;
          rem_n   = '0;
          root_n  = '0;
          cnt_n   = CW'(OW - 1);
        end
        CALC: if (!sq.EN_Sqrt) state_n = IDLE;
        else begin
          rad_n  = rad << 2;
          rem_n  = ge ? rem_sh - trial : rem_sh;
          root_n = {root[OW-2:0], ge};
          cnt_n  = (cnt == '0) ? cnt : cnt - 1'b1;
`ifdef SQRT_ROUND_EN
          state_n = (cnt == '0) ? ROUND : CALC;
`else
          state_n = (cnt == '0) ? DONE : CALC;
`endif
        end
`ifdef SQRT_ROUND_EN
        // Remainder above the floor root means the radicand lies past (root+0.5)^2
        ROUND: if (!sq.EN_Sqrt) state_n = IDLE;
        else begin
          root_n  = (rem > {2'b00, root} && !(&root)) ? root + 1'b1 : root;
          state_n = DONE;
        end
`endif
        DONE: if (sq.EN_Sqrt) begin
          rdy_n  = 1'b1;
          dout_n = root;
        end else begin
          state_n = IDLE;
          rdy_n   = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  assign sq.RDY_Sqrt  = rdy;
  assign sq.DOUT_Sqrt = dout;
`ifdef SQRT_ROUND_EN
  assign sq.BUSY_Sqrt = (state == CALC) || (state == ROUND);
`else
  assign sq.BUSY_Sqrt = (state == CALC);
`endif
endmodule

// File: tb/tb_dist_sqrt_unit.sv
// tb_dist_sqrt_unit: randomized self-checking bench against an arithmetic square-root model
module tb_dist_sqrt_unit;
  localparam int IW = 32;
  localparam int OW = IW / 2;
`ifdef SQRT_ROUND_EN
  localparam int LAT = OW + 2;
`else
  localparam int LAT = OW + 1;
`endif
  logic clk = 1'b0;
  logic RST_N = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  longint last_root = 0;
  dist_sqrt_unit_if #(.IN_WIDTH(IW)) sq ();
  dist_sqrt_unit #(.IN_WIDTH(IW)) dut (.clk(clk), .RST_N(RST_N), .sq(sq));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic longint model(input longint n);
    longint lo = 0;
    longint hi = longint'(1) << OW;
    while (hi - lo > 1) begin
      longint mid = (lo + hi) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid;
    end
`ifdef SQRT_ROUND_EN
    if (n - lo * lo > lo && lo < (longint'(1) << OW) - 1) lo = lo + 1;
`endif
    return lo;
  endfunction
  task automatic run_op(input logic [IW-1:0] din);
    longint e = model(longint'(din));
    int early = 0;
    @(negedge clk);
    sq.EN_Sqrt  = 1'b1;
    sq.DIN_Sqrt = din;
    @(posedge clk);
    #1;
    sq.DIN_Sqrt = $urandom;
    check("busy_start", 64'(sq.BUSY_Sqrt), 64'd1);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      if (k < LAT && sq.RDY_Sqrt) early++;
    end
    check("rdy_early", 64'(early), 64'd0);
    check("rdy_latency", 64'(sq.RDY_Sqrt), 64'd1);
    check("root", 64'(sq.DOUT_Sqrt), 64'(e));
    check("busy_done", 64'(sq.BUSY_Sqrt), 64'd0);
    @(negedge clk);
    sq.EN_Sqrt = 1'b0;
    @(posedge clk);
    #1;
    check("rdy_fall", 64'(sq.RDY_Sqrt), 64'd0);
    check("root_hold", 64'(sq.DOUT_Sqrt), 64'(e));
    last_root = e;
  endtask
  task automatic start_calc(input int edges);
    @(negedge clk);
    sq.EN_Sqrt  = 1'b1;
    sq.DIN_Sqrt = $urandom;
    @(posedge clk);
    repeat (edges) @(posedge clk);
  endtask
  initial begin
    logic [IW-1:0] fixed [10] = '{32'd144, 32'd157, 32'd156, 32'hFFFF_FFFF, 32'd0,
                                  32'd1, 32'd2, 32'd3, 32'd4, 32'd1000000};
    sq.RST_Sqrt = 1'b0;
    sq.EN_Sqrt  = 1'b0;
    sq.DIN_Sqrt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy", 64'(sq.RDY_Sqrt), 64'd0);
    check("reset_dout", 64'(sq.DOUT_Sqrt), 64'd0);
    check("reset_busy", 64'(sq.BUSY_Sqrt), 64'd0);
    @(negedge clk);
    RST_N = 1'b1;
    foreach (fixed[i]) run_op(fixed[i]);
    for (int i = 0; i < 24; i++)
      run_op((i % 3 == 0) ? IW'($urandom_range(0, 2000)) : IW'($urandom));
    start_calc(5);
    @(negedge clk);
    sq.EN_Sqrt = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(sq.BUSY_Sqrt), 64'd0);
    check("abort_rdy", 64'(sq.RDY_Sqrt), 64'd0);
    check("abort_dout", 64'(sq.DOUT_Sqrt), 64'(last_root));
    run_op(32'd49);
    run_op(32'd900);
    start_calc(3);
    @(negedge clk);
    sq.RST_Sqrt = 1'b1;
    sq.EN_Sqrt  = 1'b0;
    #1;
    check("soft_rst_pre", 64'(sq.DOUT_Sqrt), 64'd30);
    @(posedge clk);
    #1;
    check("soft_rst_busy", 64'(sq.BUSY_Sqrt), 64'd0);
    check("soft_rst_rdy", 64'(sq.RDY_Sqrt), 64'd0);
    check("soft_rst_dout", 64'(sq.DOUT_Sqrt), 64'd0);
    @(negedge clk);
    sq.RST_Sqrt = 1'b0;
    run_op(32'd10000);
    start_calc(4);
    #3;
    RST_N = 1'b0;
    #1;
    check("hard_rst_busy", 64'(sq.BUSY_Sqrt), 64'd0);
    check("hard_rst_rdy", 64'(sq.RDY_Sqrt), 64'd0);
    check("hard_rst_dout", 64'(sq.DOUT_Sqrt), 64'd0);
    sq.EN_Sqrt = 1'b0;
    @(negedge clk);
    RST_N = 1'b1;
    run_op(32'd625);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
